// File: rtl/cache_pkg.sv
// Types and constants shared by the instruction cache and its miss/fill controller.
package cache_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_W        = 3;
  localparam int BLOCK_BYTES     = 16;
  localparam int MEM_LATENCY     = 4;

  // Address fields, common with the cache: TAG[15:10] SET[9:4] OFFSET[3:1]
  localparam int TAG_MSB = 15;
  localparam int TAG_LSB = 10;
  localparam int SET_MSB = 9;
  localparam int SET_LSB = 4;

  localparam logic [OFFSET_W-1:0] LAST_OFF = OFFSET_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_META = 2'd2,
    ST_DONE = 2'd3
  } fill_state_e;

  function automatic logic [15:0] block_base(input logic [15:0] addr);
    return addr & ~16'(BLOCK_BYTES - 1);
  endfunction

  // Offset is spliced into [3:1], so it can never carry into the set/tag bits.
  function automatic logic [15:0] word_addr(input logic [15:0] base,
                                            input logic [OFFSET_W-1:0] off);
    return {base[TAG_MSB:SET_LSB], off, 1'b0};
  endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Word counter for one block: counts enabled cycles, saturates at the last word and flags done.
module fill_word_counter
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clr,
  input  logic                i_en,
  output logic [OFFSET_W-1:0] o_cnt,
  output logic                o_done
);

  logic [OFFSET_W-1:0] r_cnt;
  logic                r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_en && !r_done) begin
      if (r_cnt == LAST_OFF) begin
        r_done <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_done = r_done;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss handler for the two-way I-cache: fetches an 8-word block from pipelined memory,
// streams it into the cache data array, then pulses the metadata write once.
module cache_fill_ctrl
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Miss,
  input  logic [15:0] Miss_Addr,
  output logic [15:0] mem_addr,
  output logic        mem_en,
  input  logic [15:0] mem_data,
  input  logic        mem_data_valid,
  output logic [15:0] Addr_FSM,
  output logic [15:0] DataIn_FSM,
  output logic        Data_WE,
  output logic        MetaData_WE,
  output logic        fsm_busy,
  output logic [1:0]  o_dbg_state
);

  fill_state_e         r_state;
  fill_state_e         w_next_state;
  logic [15:0]         r_base;
  logic                w_start;
  logic                w_issue;
  logic                w_recv;
  logic [OFFSET_W-1:0] w_issue_cnt;
  logic [OFFSET_W-1:0] w_recv_cnt;
  logic                w_issue_done;
  logic                w_recv_done;

  assign w_start     = (r_state == ST_IDLE) && Miss;
  assign o_dbg_state = r_state;

  fill_word_counter u_issue_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_start),
    .i_en   (w_issue),
    .o_cnt  (w_issue_cnt),
    .o_done (w_issue_done)
  );

  fill_word_counter u_recv_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_start),
    .i_en   (w_recv),
    .o_cnt  (w_recv_cnt),
    .o_done (w_recv_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_base  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_base <= block_base(Miss_Addr);
      end
    end
  end

  // Request and receive sides run independently inside FILL; only the receive side ends it.
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_recv       = 1'b0;
    mem_en       = 1'b0;
    mem_addr     = '0;
    Data_WE      = 1'b0;
    DataIn_FSM   = '0;
    Addr_FSM     = '0;
    MetaData_WE  = 1'b0;
    fsm_busy     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Miss) begin
          w_next_state = ST_FILL;
        end
      end
      ST_FILL: begin
        fsm_busy = 1'b1;
        w_issue  = !w_issue_done;
        if (w_issue) begin
          mem_en   = 1'b1;
          mem_addr = word_addr(r_base, w_issue_cnt);
        end
        w_recv = mem_data_valid && !w_recv_done;
        if (w_recv) begin
          Data_WE    = 1'b1;
          DataIn_FSM = mem_data;
          Addr_FSM   = word_addr(r_base, w_recv_cnt);
          if (w_recv_cnt == LAST_OFF) begin
            w_next_state = ST_META;
          end
        end
      end
      ST_META: begin
        fsm_busy     = 1'b1;
        MetaData_WE  = 1'b1;
        Addr_FSM     = r_base;
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        // Gives the cache's registered metadata write a cycle to land before release.
        fsm_busy     = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: pipelined memory model plus scoreboards for requests,
// data-array writes and metadata writes.
module tb_cache_fill_ctrl;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Miss;
  logic [15:0] Miss_Addr;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic [15:0] mem_data = '0;
  logic        mem_data_valid = 1'b0;
  logic [15:0] Addr_FSM;
  logic [15:0] DataIn_FSM;
  logic        Data_WE;
  logic        MetaData_WE;
  logic        fsm_busy;
  logic [1:0]  o_dbg_state;

  typedef struct {
    int          due;
    logic [15:0] data;
  } mem_rsp_t;

  mem_rsp_t    pipe[$];
  logic [15:0] exp_req_q[$];
  logic [31:0] exp_wr_q[$];
  logic [15:0] exp_meta_q[$];
  int          req_cyc_q[$];
  int          meta_cyc_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          req_cnt = 0;
  int          dwe_cnt = 0;
  int          meta_cnt = 0;
  int          rise_cyc = 0;
  int          fall_cyc = 0;
  logic        prev_busy = 1'b0;
  logic        zero_req = 1'b0;
  logic        spur = 1'b0;
  logic [15:0] mem_seed = '0;
  logic [31:0] mon_e;

  cache_fill_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Miss           (Miss),
    .Miss_Addr      (Miss_Addr),
    .mem_addr       (mem_addr),
    .mem_en         (mem_en),
    .mem_data       (mem_data),
    .mem_data_valid (mem_data_valid),
    .Addr_FSM       (Addr_FSM),
    .DataIn_FSM     (DataIn_FSM),
    .Data_WE        (Data_WE),
    .MetaData_WE    (MetaData_WE),
    .fsm_busy       (fsm_busy),
    .o_dbg_state    (o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Memory model: a request seen in cycle c answers in cycle c+MEM_LATENCY.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (pipe.size() > 0 && pipe[0].due == cyc) begin
      mem_data_valid = 1'b1;
      mem_data       = pipe[0].data;
      void'(pipe.pop_front());
    end else if (spur) begin
      mem_data_valid = 1'b1;
      mem_data       = 16'hDEAD;
    end else begin
      mem_data_valid = 1'b0;
      mem_data       = '0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_en) begin
        req_cnt++;
        req_cyc_q.push_back(cyc);
        if (mem_addr == 16'h0000) zero_req = 1'b1;
        if (exp_req_q.size() == 0) check("req_extra", 1, 0);
        else check("mem_addr", mem_addr, exp_req_q.pop_front());
        pipe.push_back('{due: cyc + MEM_LATENCY, data: mem_seed + {13'b0, mem_addr[3:1]}});
      end
      if (Data_WE) begin
        dwe_cnt++;
        if (exp_wr_q.size() == 0) check("dwe_extra", 1, 0);
        else begin
          mon_e = exp_wr_q.pop_front();
          check("wr_addr", Addr_FSM, mon_e[31:16]);
          check("wr_data", DataIn_FSM, mon_e[15:0]);
        end
      end
      if (MetaData_WE) begin
        meta_cnt++;
        meta_cyc_q.push_back(cyc);
        check("meta_dwe", Data_WE, 0);
        if (exp_meta_q.size() == 0) check("meta_extra", 1, 0);
        else check("meta_addr", Addr_FSM, exp_meta_q.pop_front());
      end
      if (fsm_busy && !prev_busy) rise_cyc = cyc;
      if (!fsm_busy && prev_busy) fall_cyc = cyc;
      prev_busy = fsm_busy;
    end
  end

  task automatic expect_fill(input logic [15:0] addr, input logic [15:0] seed);
    logic [15:0] base;
    base = {addr[15:4], 4'h0};
    for (int i = 0; i < 8; i++) begin
      exp_req_q.push_back(base + 16'(2 * i));
      exp_wr_q.push_back({base + 16'(2 * i), seed + 16'(i)});
    end
    exp_meta_q.push_back(base);
    mem_seed = seed;
  endtask

  task automatic wait_meta(input string tag);
    int m0;
    int n;
    m0 = meta_cnt;
    n  = 0;
    while (meta_cnt == m0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (meta_cnt == m0) check(tag, 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (fsm_busy && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (fsm_busy) check(tag, 1, 0);
  endtask

  task automatic run_fill(input logic [15:0] addr, input logic [15:0] seed, input bit spur_done);
    int m0, d0, r0, mc;
    m0 = meta_cnt;
    d0 = dwe_cnt;
    r0 = req_cnt;
    expect_fill(addr, seed);
    @(posedge clk); #1;
    Miss_Addr = addr;
    Miss      = 1'b1;
    mc        = cyc;
    @(posedge clk); #1;
    Miss = 1'b0;
    wait_meta("meta_timeout");
    if (spur_done) begin
      spur = 1'b1;
      @(negedge clk); #1;
      check("done_state", o_dbg_state, ST_DONE);
      check("done_spur_dwe", Data_WE, 0);
      spur = 1'b0;
    end
    wait_idle("idle_timeout");
    check("busy_rise", rise_cyc - mc, 1);
    check("busy_fall", fall_cyc - mc, 15);
    check("meta_cnt", meta_cnt - m0, 1);
    check("dwe_cnt", dwe_cnt - d0, 8);
    check("req_cnt", req_cnt - r0, 8);
    check("wr_q_left", exp_wr_q.size(), 0);
  endtask

  initial begin
    int d0, m0, n;
    rst_n     = 1'b0;
    Miss      = 1'b0;
    Miss_Addr = '0;
    #3;
    check("rst_outs", {mem_en, Data_WE, MetaData_WE, fsm_busy, mem_addr, Addr_FSM, DataIn_FSM}, 0);
    check("rst_state", o_dbg_state, ST_IDLE);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk); #1;

    run_fill(16'h1236, 16'hA000, 1'b0);

    zero_req = 1'b0;
    run_fill(16'hFFFA, 16'h5000, 1'b0);
    check("no_zero_addr", zero_req, 0);

    // Miss held high, address moved mid-fill
    m0 = meta_cnt;
    d0 = dwe_cnt;
    expect_fill(16'h3C8E, 16'h1100);
    @(posedge clk); #1;
    Miss_Addr = 16'h3C8E;
    Miss      = 1'b1;
    repeat (5) @(posedge clk);
    #1 Miss_Addr = 16'h4000;
    wait_meta("hold_meta_timeout");
    @(posedge clk); #1;
    Miss = 1'b0;
    wait_idle("hold_idle_timeout");
    repeat (3) @(negedge clk);
    #1;
    check("hold_meta_cnt", meta_cnt - m0, 1);
    check("hold_dwe_cnt", dwe_cnt - d0, 8);
    check("hold_state", o_dbg_state, ST_IDLE);

    // Spurious valid in IDLE, then in DONE
    d0   = dwe_cnt;
    spur = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check("idle_spur_state", o_dbg_state, ST_IDLE);
      check("idle_spur_busy", fsm_busy, 0);
    end
    spur = 1'b0;
    check("idle_spur_dwe", dwe_cnt - d0, 0);
    run_fill(16'h0AB2, 16'h6000, 1'b1);

    // Reset after the third word
    m0 = meta_cnt;
    d0 = dwe_cnt;
    expect_fill(16'h8A54, 16'hC000);
    @(posedge clk); #1;
    Miss_Addr = 16'h8A54;
    Miss      = 1'b1;
    @(posedge clk); #1;
    Miss = 1'b0;
    n = 0;
    while (dwe_cnt - d0 < 3 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("rst_third_word", dwe_cnt - d0, 3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {mem_en, Data_WE, MetaData_WE, fsm_busy, mem_addr, Addr_FSM, DataIn_FSM}, 0);
    check("midrst_state", o_dbg_state, ST_IDLE);
    pipe.delete();
    exp_req_q.delete();
    exp_wr_q.delete();
    exp_meta_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk); #1;
    check("midrst_no_meta", meta_cnt - m0, 0);
    run_fill(16'h8A54, 16'hC100, 1'b0);

    // Back-to-back misses
    req_cyc_q.delete();
    meta_cyc_q.delete();
    expect_fill(16'h0100, 16'h3000);
    expect_fill(16'h0200, 16'h3000);
    @(posedge clk); #1;
    Miss_Addr = 16'h0100;
    Miss      = 1'b1;
    wait_meta("b2b_meta1_timeout");
    @(posedge clk); #1;
    Miss_Addr = 16'h0200;
    @(posedge clk); #1;
    check("b2b_idle_busy", fsm_busy, 0);
    @(posedge clk); #1;
    Miss = 1'b0;
    wait_meta("b2b_meta2_timeout");
    wait_idle("b2b_idle_timeout");
    check("b2b_meta_n", meta_cyc_q.size(), 2);
    check("b2b_req_n", req_cyc_q.size(), 16);
    if (meta_cyc_q.size() == 2 && req_cyc_q.size() == 16) begin
      check("b2b_gap", (meta_cyc_q[1] - meta_cyc_q[0]) >= 15, 1);
      check("b2b_second_start", req_cyc_q[8] - meta_cyc_q[0], 3);
    end
    check("b2b_wr_left", exp_wr_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    check("watchdog", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
